// File: rtl/irq_ctrl_if.sv
// Execute-stage and config-port signal bundle for irq_ctrl.
// The master drives requests and config writes; the slave is the controller.
interface irq_ctrl_if #(
  parameter int unsigned NUM_SRC = 7
);
  logic [NUM_SRC-1:0] irq_i;
  logic               int_en_i;
  logic               exc_i;
  logic               cfg_we_i;
  logic [1:0]         cfg_addr_i;
  logic [31:0]        cfg_data_i;
  logic [31:0]        cfg_data_o;
  logic [2:0]         interrupts_o;

  modport master (
    output irq_i, int_en_i, exc_i, cfg_we_i, cfg_addr_i, cfg_data_i,
    input  cfg_data_o, interrupts_o
  );

  modport slave (
    input  irq_i, int_en_i, exc_i, cfg_we_i, cfg_addr_i, cfg_data_i,
    output cfg_data_o, interrupts_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks up to 7 request lines and presents one vector to execute.
// Optional IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of the sampling register.
module irq_ctrl #(
  parameter int unsigned NUM_SRC = 7
) (
  input  logic     clk_i,
  input  logic     rst_i,
  irq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] w_irq_in;
  logic [NUM_SRC-1:0] r_irq_s, r_irq_d;
  logic [NUM_SRC-1:0] r_pend, r_mask, r_edge;
  logic [2:0]         r_vec, r_int;
  logic               r_en_d;

  logic [NUM_SRC-1:0] w_rise, w_elig, w_pres_oh, w_exc_clr, w_w1c, w_pend_nxt;
  logic [2:0]         w_top, w_vec_nxt, w_int_nxt;
  logic               w_pres_live;
  logic [31:0]        w_rd;
  logic               w_unused_cfg;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_in = r_sync2;
`else
  assign w_irq_in = bus.irq_i;
`endif

  assign w_rise      = r_irq_s & ~r_irq_d;
  assign w_elig      = r_pend & r_mask;
  assign w_pres_live = |(w_pres_oh & w_elig);
  assign w_w1c       = (bus.cfg_we_i && bus.cfg_addr_i == 2'd2) ? bus.cfg_data_i[NUM_SRC-1:0] : '0;

  // A fresh edge outranks any clear on the same cycle; level bits just track the sample.
  assign w_pend_nxt  = (r_edge & ((r_pend & ~(w_w1c | w_exc_clr)) | w_rise)) |
                       (~r_edge & r_irq_s);

  always_comb begin
    w_top     = '0;
    w_pres_oh = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i]) w_top = 3'(i + 1);
      w_pres_oh[i] = (r_vec == 3'(i + 1));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_int_nxt   = r_int;
    w_exc_clr   = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig && bus.int_en_i) begin
          w_state_nxt = S_PRESENT;
          w_vec_nxt   = w_top;
          w_int_nxt   = w_top;
        end
      end
      S_PRESENT: begin
        if (bus.exc_i) begin
          w_state_nxt = S_WAIT;
          w_int_nxt   = '0;
          w_exc_clr   = w_pres_oh;
        end else if (!bus.int_en_i || !w_pres_live) begin
          w_state_nxt = S_IDLE;
          w_vec_nxt   = '0;
          w_int_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (bus.int_en_i && !r_en_d) begin
          w_state_nxt = S_IDLE;
          w_vec_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_vec_nxt   = '0;
        w_int_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_irq_s <= '0;
      r_irq_d <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_vec   <= '0;
      r_int   <= '0;
      r_en_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq_s <= w_irq_in;
      r_irq_d <= r_irq_s;
      r_pend  <= w_pend_nxt;
      r_vec   <= w_vec_nxt;
      r_int   <= w_int_nxt;
      r_en_d  <= bus.int_en_i;
      if (bus.cfg_we_i && bus.cfg_addr_i == 2'd0) r_mask <= bus.cfg_data_i[NUM_SRC-1:0];
      if (bus.cfg_we_i && bus.cfg_addr_i == 2'd1) r_edge <= bus.cfg_data_i[NUM_SRC-1:0];
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.cfg_addr_i)
      2'd0:    w_rd = {{(32 - NUM_SRC){1'b0}}, r_mask};
      2'd1:    w_rd = {{(32 - NUM_SRC){1'b0}}, r_edge};
      2'd2:    w_rd = {{(32 - NUM_SRC){1'b0}}, r_pend};
      default: w_rd = {24'h0, r_state, 3'b000, r_vec};
    endcase
  end

  assign w_unused_cfg     = ^bus.cfg_data_i[31:NUM_SRC];
  assign bus.cfg_data_o   = w_rd;
  assign bus.interrupts_o = r_int;
endmodule
